// File: rtl/rf_wb_sched.sv
// Write-port scheduler for the integer register file, with a pending-write scoreboard
// that tracks destinations of in-flight long-latency ops for decode hazard stalls.
module rf_wb_sched #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alloc_valid_i,
  input  logic [4:0]      alloc_rd_i,
  output logic            alloc_ready_o,
  input  logic            pipe_valid_i,
  input  logic [4:0]      pipe_addr_i,
  input  logic [XLEN-1:0] pipe_data_i,
  output logic            pipe_ready_o,
  input  logic            ll_valid_i,
  input  logic [4:0]      ll_addr_i,
  input  logic [XLEN-1:0] ll_data_i,
  output logic            ll_ready_o,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            rd_busy_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          starved;
  logic          pipe_hs, ll_hs, alloc_hs;

  // Once the long-latency source has waited STARVE_LIMIT cycles it wins ties.
  assign starved      = (starve_q == STARVE_MAX);
  assign pipe_ready_o = starved ? !ll_valid_i : 1'b1;
  assign ll_ready_o   = starved ? 1'b1 : !pipe_valid_i;

  assign pipe_hs  = pipe_valid_i & pipe_ready_o;
  assign ll_hs    = ll_valid_i & ll_ready_o;

  assign alloc_ready_o = (alloc_rd_i == 5'd0) || !busy_q[alloc_rd_i];
  assign alloc_hs      = alloc_valid_i & alloc_ready_o;

  always_comb begin
    rf_waddr_o = 5'd0;
    rf_wdata_o = '0;
    if (ll_hs) begin
      rf_waddr_o = ll_addr_i;
      rf_wdata_o = ll_data_i;
    end else if (pipe_hs) begin
      rf_waddr_o = pipe_addr_i;
      rf_wdata_o = pipe_data_i;
    end
  end

  // x0 writes complete the handshake but never reach the array.
  assign rf_we_o = (pipe_hs | ll_hs) && (rf_waddr_o != 5'd0);

  always_comb begin
    starve_d = '0;
    if (ll_valid_i && !ll_ready_o) begin
      starve_d = starved ? starve_q : starve_q + CW'(1);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (ll_hs) begin
      busy_d[ll_addr_i] = 1'b0;
    end
    if (alloc_hs) begin
      busy_d[alloc_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  // Queries see only the registered vector; a retiring write is still reported busy.
  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rd_busy_o  = busy_q[rd_addr_i];

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: stimulus pushes expected snapshots into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rf_wb_sched;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            pr;
    logic            lr;
    logic            ar;
    logic            b1;
    logic            b2;
    logic            bd;
  } snap_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            alloc_valid_i = 1'b0;
  logic [4:0]      alloc_rd_i = '0;
  logic            alloc_ready_o;
  logic            pipe_valid_i = 1'b0;
  logic [4:0]      pipe_addr_i = '0;
  logic [XLEN-1:0] pipe_data_i = '0;
  logic            pipe_ready_o;
  logic            ll_valid_i = 1'b0;
  logic [4:0]      ll_addr_i = '0;
  logic [XLEN-1:0] ll_data_i = '0;
  logic            ll_ready_o;
  logic [4:0]      rs1_addr_i = '0;
  logic [4:0]      rs2_addr_i = '0;
  logic [4:0]      rd_addr_i = '0;
  logic            rs1_busy_o, rs2_busy_o, rd_busy_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  snap_t exp_q[$];
  string name_q[$];

  always #5 clk_i = ~clk_i;

  rf_wb_sched #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_rd_i(alloc_rd_i), .alloc_ready_o(alloc_ready_o),
    .pipe_valid_i(pipe_valid_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .pipe_ready_o(pipe_ready_o),
    .ll_valid_i(ll_valid_i), .ll_addr_i(ll_addr_i), .ll_data_i(ll_data_i), .ll_ready_o(ll_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .rd_busy_o(rd_busy_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  function automatic snap_t ex(input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                               input logic pr, input logic lr, input logic ar,
                               input logic b1, input logic b2, input logic bd);
    snap_t s;
    s.we = we; s.waddr = wa; s.wdata = wd;
    s.pr = pr; s.lr = lr; s.ar = ar;
    s.b1 = b1; s.b2 = b2; s.bd = bd;
    return s;
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic pv, input logic [4:0] pa, input logic [XLEN-1:0] pd,
                       input logic lv, input logic [4:0] la, input logic [XLEN-1:0] ld,
                       input logic av, input logic [4:0] ard,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    @(posedge clk_i);
    #1;
    pipe_valid_i = pv; pipe_addr_i = pa; pipe_data_i = pd;
    ll_valid_i = lv; ll_addr_i = la; ll_data_i = ld;
    alloc_valid_i = av; alloc_rd_i = ard;
    rs1_addr_i = r1; rs2_addr_i = r2; rd_addr_i = rd;
  endtask

  task automatic push(input string nm, input snap_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = ex(rf_we_o, rf_waddr_o, rf_wdata_o, pipe_ready_o, ll_ready_o, alloc_ready_o,
             rs1_busy_o, rs2_busy_o, rd_busy_o);
      total_cnt++;
      if (a === e) begin
        pass_cnt++;
        $display("txn %-14s ok   we=%0b waddr=%0d wdata=%h pr=%0b lr=%0b ar=%0b busy=%0b%0b%0b",
                 nm, a.we, a.waddr, a.wdata, a.pr, a.lr, a.ar, a.b1, a.b2, a.bd);
      end else begin
        $display("FAIL %s: got we=%0b waddr=%0d wdata=%h pr=%0b lr=%0b ar=%0b busy=%0b%0b%0b, want we=%0b waddr=%0d wdata=%h pr=%0b lr=%0b ar=%0b busy=%0b%0b%0b",
                 nm, a.we, a.waddr, a.wdata, a.pr, a.lr, a.ar, a.b1, a.b2, a.bd,
                 e.we, e.waddr, e.wdata, e.pr, e.lr, e.ar, e.b1, e.b2, e.bd);
      end
    end
  end

  initial begin
    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("reset", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    rst_ni = 1'b1;

    // Pipeline write lands with zero latency
    drive(1, 5, 'hA5, 0, 0, 0, 0, 0, 0, 0, 0);
    push("pipe_wr", ex(1, 5, 'hA5, 1, 0, 1, 0, 0, 0));

    // Contention: pipe wins 4 cycles, ll wins on 5th, then counter is back to 0
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, 100 + i, 1, 2, 'hBB, 0, 0, 0, 0, 0);
      push("starve_pipe", ex(1, 10, 100 + i, 1, 0, 1, 0, 0, 0));
    end
    drive(1, 10, 104, 1, 2, 'hBB, 0, 0, 0, 0, 0);
    push("starve_ll", ex(1, 2, 'hBB, 0, 1, 1, 0, 0, 0));
    drive(1, 10, 104, 1, 3, 'hCC, 0, 0, 0, 0, 0);
    push("starve_rearm", ex(1, 10, 104, 1, 0, 1, 0, 0, 0));

    // Reserve x7, re-alloc blocked, retire clears one cycle later
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 7);
    push("alloc7", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 7);
    push("alloc7_again", ex(0, 0, 0, 1, 1, 0, 1, 0, 1));
    drive(0, 0, 0, 1, 7, 'h77, 0, 0, 7, 0, 0);
    push("retire7", ex(1, 7, 'h77, 1, 1, 1, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    push("x7_free", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));

    // x0 traffic: accepted, discarded
    drive(0, 0, 0, 1, 0, 'hDEAD, 1, 0, 0, 7, 0);
    push("x0_wr_alloc", ex(0, 0, 'hDEAD, 1, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    push("x0_after", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));

    // Alloc x3 while retiring x9 in the same cycle
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    push("alloc9", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 1, 9, 'h99, 1, 3, 3, 9, 0);
    push("alloc3_ret9", ex(1, 9, 'h99, 1, 1, 1, 0, 1, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 9);
    push("after_3_9", ex(0, 0, 0, 1, 1, 1, 1, 0, 0));

    // busy[4]=1, starve_cnt=3, then async reset mid-cycle
    drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    push("alloc4", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive(1, 11, 200 + i, 1, 20, 'hEE, 0, 0, 3, 0, 4);
      push("pre_rst", ex(1, 11, 200 + i, 1, 0, 1, 1, 0, 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 4);
    rst_ni = 1'b0;
    push("mid_rst", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 4);
    push("rst_hold", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));
    rst_ni = 1'b1;

    // Counter restarted from 0: full 4 pipe cycles before ll wins
    for (int i = 0; i < 4; i++) begin
      drive(1, 11, 300 + i, 1, 20, 'hEE, 0, 0, 3, 0, 4);
      push("post_rst_pipe", ex(1, 11, 300 + i, 1, 0, 1, 0, 0, 0));
    end
    drive(1, 11, 304, 1, 20, 'hEE, 0, 0, 3, 0, 4);
    push("post_rst_ll", ex(1, 20, 'hEE, 0, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push("idle", ex(0, 0, 0, 1, 1, 1, 0, 0, 0));

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
